// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and two joysticks onto per-player arcade control vectors
// with optional rotation, per-player autofire and a fixed-length coin pulse.
module arcade_input_mapper #(
   parameter int          NPLAYERS    = 2,
   parameter int          AF_FRAMES   = 4,
   parameter logic [15:0] COIN_CYCLES = 16'd1800
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [10:0]           ps2_key,
   input  logic [15:0]           joystick_0,
   input  logic [15:0]           joystick_1,
   input  logic                  merge_joy,
   input  logic                  rotate,
   input  logic                  autofire_en,
   input  logic                  vblank,
   output logic [NPLAYERS*8-1:0] ctrl,
   output logic                  coin
);

   localparam int K_UP     = 0;
   localparam int K_DOWN   = 1;
   localparam int K_LEFT   = 2;
   localparam int K_RIGHT  = 3;
   localparam int K_FIRE   = 4;
   localparam int K_BOMB   = 5;
   localparam int K_START1 = 6;
   localparam int K_START2 = 7;
   localparam int K_COIN   = 8;

   localparam logic [7:0] AF_LAST = 8'(AF_FRAMES - 1);

   logic                  tog_q, tog_d;
   logic                  init_q, init_d;
   logic [8:0]            keys_q, keys_d;
   logic                  key_evt;
   logic                  vb_q, vb_d;
   logic                  vb_rise;
   logic [7:0]            af_cnt_q [NPLAYERS];
   logic [7:0]            af_cnt_d [NPLAYERS];
   logic [NPLAYERS-1:0]   af_ph_q, af_ph_d;
   logic [NPLAYERS-1:0]   fire_prev_q, fire_prev_d;
   logic                  coin_prev_q, coin_prev_d;
   logic [15:0]           coin_cnt_q, coin_cnt_d;
   logic [NPLAYERS*8-1:0] ctrl_q, ctrl_d;

   logic [7:0]            joy_m;
   logic [5:0]            joy_sel [2];
   logic [5:0]            raw [2];
   logic [1:0]            start_raw;
   logic                  coin_src;
   logic [3:0]            dir;
   logic                  fire;
   logic                  unused_ok;

   assign unused_ok = ^{joystick_0[15:8], joystick_1[15:8], ps2_key[8]};

   // The first cycle out of reset only captures the toggle bit, so a toggle
   // level left high across reset is never mistaken for a new event.
   always_comb begin
      key_evt = init_q && (ps2_key[10] != tog_q);
      tog_d   = ps2_key[10];
      init_d  = 1'b1;
      keys_d  = keys_q;
      if (key_evt) begin
         case (ps2_key[7:0])
            8'h75:   keys_d[K_UP]     = ps2_key[9];
            8'h72:   keys_d[K_DOWN]   = ps2_key[9];
            8'h6B:   keys_d[K_LEFT]   = ps2_key[9];
            8'h74:   keys_d[K_RIGHT]  = ps2_key[9];
            8'h29:   keys_d[K_FIRE]   = ps2_key[9];
            8'h14:   keys_d[K_BOMB]   = ps2_key[9];
            8'h05:   keys_d[K_START1] = ps2_key[9];
            8'h06:   keys_d[K_START2] = ps2_key[9];
            8'h2E:   keys_d[K_COIN]   = ps2_key[9];
            default: ;
         endcase
      end
   end

   always_comb begin
      joy_m      = joystick_0[7:0] | joystick_1[7:0];
      joy_sel[0] = merge_joy ? joy_m[5:0] : joystick_0[5:0];
      joy_sel[1] = merge_joy ? 6'd0 : joystick_1[5:0];
      raw[0]     = joy_sel[0] | {keys_q[K_BOMB], keys_q[K_FIRE], keys_q[K_UP],
                                 keys_q[K_DOWN], keys_q[K_LEFT], keys_q[K_RIGHT]};
      raw[1]     = joy_sel[1];
      // Start buttons always come from the merged word so either stick can start.
      start_raw  = {keys_q[K_START2] | joy_m[7], keys_q[K_START1] | joy_m[6]};
      coin_src   = start_raw[0] | start_raw[1] | keys_q[K_COIN];
   end

   always_comb begin
      vb_rise     = vblank & ~vb_q;
      vb_d        = vblank;
      ctrl_d      = '0;
      dir         = '0;
      fire        = 1'b0;
      af_ph_d     = af_ph_q;
      fire_prev_d = fire_prev_q;
      for (int p = 0; p < NPLAYERS; p++) begin
         af_cnt_d[p]    = af_cnt_q[p];
         fire_prev_d[p] = raw[p][4];
         dir = rotate ? {raw[p][1], raw[p][0], raw[p][2], raw[p][3]} : raw[p][3:0];
         // A fresh press restarts the period with fire on, even on a vblank edge.
         if (raw[p][4] && !fire_prev_q[p]) begin
            af_cnt_d[p] = 8'd0;
            af_ph_d[p]  = 1'b1;
         end else if (vb_rise) begin
            if (af_cnt_q[p] == AF_LAST) begin
               af_cnt_d[p] = 8'd0;
               af_ph_d[p]  = ~af_ph_q[p];
            end else begin
               af_cnt_d[p] = af_cnt_q[p] + 8'd1;
            end
         end
         fire = raw[p][4] & (autofire_en ? af_ph_d[p] : 1'b1);
         ctrl_d[8*p +: 8] = {1'b0, start_raw[p], raw[p][5], fire, dir};
      end
   end

   always_comb begin
      coin_prev_d = coin_src;
      coin_cnt_d  = coin_cnt_q;
      if (coin_cnt_q != 16'd0) begin
         coin_cnt_d = coin_cnt_q - 16'd1;
      end else if (coin_src && !coin_prev_q) begin
         coin_cnt_d = COIN_CYCLES;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         tog_q       <= 1'b0;
         init_q      <= 1'b0;
         keys_q      <= '0;
         vb_q        <= 1'b0;
         af_ph_q     <= '1;
         fire_prev_q <= '0;
         coin_prev_q <= 1'b0;
         coin_cnt_q  <= 16'd0;
         ctrl_q      <= '0;
         for (int p = 0; p < NPLAYERS; p++) begin
            af_cnt_q[p] <= 8'd0;
         end
      end else begin
         tog_q       <= tog_d;
         init_q      <= init_d;
         keys_q      <= keys_d;
         vb_q        <= vb_d;
         af_ph_q     <= af_ph_d;
         fire_prev_q <= fire_prev_d;
         coin_prev_q <= coin_prev_d;
         coin_cnt_q  <= coin_cnt_d;
         ctrl_q      <= ctrl_d;
         for (int p = 0; p < NPLAYERS; p++) begin
            af_cnt_q[p] <= af_cnt_d[p];
         end
      end
   end

   assign ctrl = ctrl_q;
   assign coin = (coin_cnt_q != 16'd0);

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_arcade_input_mapper;

   localparam int AF = 2;
   localparam int CC = 5;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b1;
   logic [10:0] ps2_key = '0;
   logic [15:0] joystick_0 = '0;
   logic [15:0] joystick_1 = '0;
   logic        merge_joy = 1'b0;
   logic        rotate = 1'b0;
   logic        autofire_en = 1'b0;
   logic        vblank = 1'b0;
   logic [15:0] ctrl;
   logic        coin;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   arcade_input_mapper #(
      .NPLAYERS   (2),
      .AF_FRAMES  (AF),
      .COIN_CYCLES(16'(CC))
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .merge_joy  (merge_joy),
      .rotate     (rotate),
      .autofire_en(autofire_en),
      .vblank     (vblank),
      .ctrl       (ctrl),
      .coin       (coin)
   );

   always #5 clk_sys = ~clk_sys;

   // Behavioural model. Key slots: 0 up,1 down,2 left,3 right,4 fire,5 bomb,
   // 6 start1,7 start2,8 coin.
   bit        m_kb [9];
   bit        m_seen = 0;
   bit        m_tog = 0;
   bit        m_vb = 0;
   int        m_frames [2];
   bit        m_ph [2];
   bit        m_fprev [2];
   bit        m_cprev = 0;
   int        m_cyc = 0;
   int        m_plast = -100;
   logic [15:0] m_ctrl = '0;
   logic      m_coin = 1'b0;

   logic [7:0] mj;
   logic [7:0] ms [2];
   bit u, d, l, r, f, b, s, vrise, src, ef;
   int idx, n;

   function automatic int key_slot(input logic [7:0] code);
      case (code)
         8'h75: return 0;
         8'h72: return 1;
         8'h6B: return 2;
         8'h74: return 3;
         8'h29: return 4;
         8'h14: return 5;
         8'h05: return 6;
         8'h06: return 7;
         8'h2E: return 8;
         default: return -1;
      endcase
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 9; k++) m_kb[k] = 0;
         for (int p = 0; p < 2; p++) begin
            m_frames[p] = 0;
            m_ph[p] = 1;
            m_fprev[p] = 0;
         end
         m_seen = 0; m_tog = 0; m_vb = 0; m_cprev = 0;
         m_cyc = 0; m_plast = -100; m_ctrl = '0; m_coin = 1'b0;
      end else begin
         mj = joystick_0[7:0] | joystick_1[7:0];
         ms[0] = merge_joy ? mj : joystick_0[7:0];
         ms[1] = merge_joy ? 8'h00 : joystick_1[7:0];
         vrise = vblank && !m_vb;
         m_vb = vblank;
         for (int p = 0; p < 2; p++) begin
            r = ms[p][0] | (p == 0 && m_kb[3]);
            l = ms[p][1] | (p == 0 && m_kb[2]);
            d = ms[p][2] | (p == 0 && m_kb[1]);
            u = ms[p][3] | (p == 0 && m_kb[0]);
            f = ms[p][4] | (p == 0 && m_kb[4]);
            b = ms[p][5] | (p == 0 && m_kb[5]);
            s = (p == 0) ? (mj[6] | m_kb[6]) : (mj[7] | m_kb[7]);
            if (f && !m_fprev[p]) begin
               m_frames[p] = 0;
               m_ph[p] = 1;
            end else if (vrise) begin
               if (m_frames[p] == AF - 1) begin
                  m_frames[p] = 0;
                  m_ph[p] = !m_ph[p];
               end else begin
                  m_frames[p]++;
               end
            end
            m_fprev[p] = f;
            ef = f && (autofire_en ? m_ph[p] : 1'b1);
            if (rotate) m_ctrl[8*p +: 8] = {1'b0, s, b, ef, l, r, d, u};
            else        m_ctrl[8*p +: 8] = {1'b0, s, b, ef, u, d, l, r};
         end
         src = mj[6] | m_kb[6] | mj[7] | m_kb[7] | m_kb[8];
         m_cyc++;
         n = m_cyc;
         if (n > m_plast + 1 && src && !m_cprev) m_plast = n + CC - 1;
         m_cprev = src;
         m_coin = (n <= m_plast);
         if (m_seen && ps2_key[10] != m_tog) begin
            idx = key_slot(ps2_key[7:0]);
            if (idx >= 0) m_kb[idx] = ps2_key[9];
         end
         m_tog = ps2_key[10];
         m_seen = 1;
      end
   end

   always @(negedge clk_sys) begin
      if (chk_en) begin
         total++;
         if (ctrl !== m_ctrl || coin !== m_coin) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t ctrl got %h expected %h coin got %b expected %b",
                     $time, ctrl, m_ctrl, coin, m_coin);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int k);
      repeat (k) @(posedge clk_sys);
      #2;
   endtask

   logic [7:0] codes [11] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14,
                              8'h05, 8'h06, 8'h2E, 8'h1C, 8'h00};
   logic [7:0] af_exp = 8'b1001_1001;
   int ones;

   initial begin
      #1 reset_n = 1'b0;
      chk_en = 1'b1;
      wait_edges(2);
      chk("reset_ctrl", 32'(ctrl), 32'h0);
      chk("reset_coin", 32'(coin), 32'h0);
      reset_n = 1'b1;
      wait_edges(2);

      // Keyboard up: two-cycle latency.
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
      wait_edges(1);
      chk("key_up_lat1", 32'(ctrl[3]), 32'h0);
      wait_edges(1);
      chk("key_up_lat2", 32'(ctrl[3]), 32'h1);
      ps2_key = {1'b0, 1'b0, 1'b0, 8'h75};
      wait_edges(2);
      chk("key_up_release", 32'(ctrl[3]), 32'h0);

      // Rotation: left stick becomes up.
      rotate = 1'b1;
      joystick_0 = 16'h0002;
      wait_edges(1);
      chk("rot_up", 32'(ctrl[3]), 32'h1);
      chk("rot_left", 32'(ctrl[1]), 32'h0);
      chk("rot_p1", 32'(ctrl[7:0]), 32'h08);

      // Merge selection.
      rotate = 1'b0;
      joystick_0 = 16'h0000;
      joystick_1 = 16'h0010;
      wait_edges(1);
      chk("sep_p2_fire", 32'(ctrl[12]), 32'h1);
      chk("sep_p1_fire", 32'(ctrl[4]), 32'h0);
      merge_joy = 1'b1;
      wait_edges(1);
      chk("merge_p1_fire", 32'(ctrl[4]), 32'h1);
      chk("merge_p2_fire", 32'(ctrl[12]), 32'h0);

      // Autofire with two frames per half-period.
      merge_joy = 1'b0;
      joystick_1 = 16'h0000;
      autofire_en = 1'b1;
      wait_edges(3);
      joystick_0 = 16'h0010;
      wait_edges(1);
      chk("af_first", 32'(ctrl[4]), 32'h1);
      for (int k = 0; k < 8; k++) begin
         vblank = 1'b1;
         wait_edges(2);
         vblank = 1'b0;
         wait_edges(2);
         chk($sformatf("af_vb%0d", k), 32'(ctrl[4]), 32'(af_exp[k]));
      end
      joystick_0 = 16'h0000;
      wait_edges(1);
      chk("af_release", 32'(ctrl[4]), 32'h0);
      autofire_en = 1'b0;
      wait_edges(2);

      // Coin pulse with a second press inside it.
      ones = 0;
      for (int i = 0; i < 20; i++) begin
         joystick_0 = (i == 0 || i == 3) ? 16'h0040 : 16'h0000;
         wait_edges(1);
         if (i == 0) chk("coin_start", 32'(coin), 32'h1);
         if (coin) ones++;
      end
      chk("coin_len", 32'(ones), 32'(CC));

      // Reset mid-pulse, toggle bit high across release.
      joystick_0 = 16'h0040;
      wait_edges(1);
      joystick_0 = 16'h0000;
      wait_edges(1);
      chk("coin_mid", 32'(coin), 32'h1);
      #1 reset_n = 1'b0;
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
      #1 chk("coin_async_clr", 32'(coin), 32'h0);
      wait_edges(2);
      reset_n = 1'b1;
      wait_edges(4);
      chk("post_rst_ctrl", 32'(ctrl), 32'h0);
      chk("post_rst_coin", 32'(coin), 32'h0);
      ps2_key = {1'b0, 1'b1, 1'b0, 8'h75};
      wait_edges(2);
      chk("post_rst_key", 32'(ctrl[3]), 32'h1);
      ps2_key = {1'b1, 1'b0, 1'b0, 8'h75};
      wait_edges(2);

      for (int i = 0; i < 3000; i++) begin
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
         if ($urandom_range(0, 3) == 0) joystick_0 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) joystick_1 = 16'($urandom);
         case ($urandom_range(0, 5))
            0: ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), codes[$urandom_range(0, 10)]};
            1: ps2_key[9:0] = 10'($urandom);
            default: ;
         endcase
         if ($urandom_range(0, 2) == 0) vblank = ~vblank;
         if ($urandom_range(0, 39) == 0) merge_joy = ~merge_joy;
         if ($urandom_range(0, 39) == 0) rotate = ~rotate;
         if ($urandom_range(0, 39) == 0) autofire_en = ~autofire_en;
         wait_edges(1);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
